// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer-side bundle for sync_fifo_fwft; the FIFO uses the slave
// modport, the surrounding logic uses master.
interface sync_fifo_fwft_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CNT_WIDTH  = 5
);
    logic                    i_wren;
    logic [P_DATA_WIDTH-1:0] i_wdata;
    logic                    i_rden;
    logic [P_DATA_WIDTH-1:0] o_rdata;
    logic                    o_rddata_valid;
    logic                    o_fifo_full;
    logic                    o_fifo_empty;
    logic [P_CNT_WIDTH-1:0]  i_cfg_almost_full;
    logic [P_CNT_WIDTH-1:0]  i_cfg_almost_empty;
    logic                    o_fifo_almost_full;
    logic                    o_fifo_almost_empty;
    logic [P_CNT_WIDTH-1:0]  o_fifo_level;
    logic                    i_err_clr;
    logic                    o_overflow;
    logic                    o_underflow;

    modport master (
        output i_wren, i_wdata, i_rden, i_cfg_almost_full, i_cfg_almost_empty, i_err_clr,
        input  o_rdata, o_rddata_valid, o_fifo_full, o_fifo_empty, o_fifo_almost_full,
               o_fifo_almost_empty, o_fifo_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_wren, i_wdata, i_rden, i_cfg_almost_full, i_cfg_almost_empty, i_err_clr,
        output o_rdata, o_rddata_valid, o_fifo_full, o_fifo_empty, o_fifo_almost_full,
               o_fifo_almost_empty, o_fifo_level, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO, arbitrary depth, standard or FWFT read, flags from a registered level.
// Define SYNC_FIFO_ERR_FLAGS_EN to get sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_FWFT       = 0,
    parameter int P_CNT_WIDTH  = $clog2(P_FIFO_DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sync_fifo_fwft_if.slave bus
);
    localparam int PW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam logic [PW-1:0]          PTR_LAST = PW'(P_FIFO_DEPTH - 1);
    localparam logic [P_CNT_WIDTH-1:0] LVL_FULL = P_CNT_WIDTH'(P_FIFO_DEPTH);

    logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [P_CNT_WIDTH-1:0]  level_q, level_d;
    logic                    full, empty, wr_acc, rd_acc;

    // Blocking is judged on the registered state only; a same-cycle pop never frees a slot.
    assign full   = (level_q == LVL_FULL);
    assign empty  = (level_q == '0);
    assign wr_acc = bus.i_wren & ~full;
    assign rd_acc = bus.i_rden & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        if (wr_acc && !rd_acc)      level_d = level_q + P_CNT_WIDTH'(1);
        else if (rd_acc && !wr_acc) level_d = level_q - P_CNT_WIDTH'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.i_wdata;
    end

    assign bus.o_fifo_full         = full;
    assign bus.o_fifo_empty        = empty;
    assign bus.o_fifo_level        = level_q;
    assign bus.o_fifo_almost_full  = (level_q >= bus.i_cfg_almost_full);
    assign bus.o_fifo_almost_empty = (level_q <= bus.i_cfg_almost_empty);

    generate
        if (P_FWFT != 0) begin : g_fwft
            // Head word is shown as soon as it is stored; zeros when nothing is held.
            assign bus.o_rddata_valid = ~empty;
            assign bus.o_rdata        = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [P_DATA_WIDTH-1:0] rdata_q;
            logic                    rvalid_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
                end
            end
            assign bus.o_rdata        = rdata_q;
            assign bus.o_rddata_valid = rvalid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new violation in the clear cycle keeps the flag set.
    assign ovf_d = (bus.i_wren & full)  | (ovf_q & ~bus.i_err_clr);
    assign udf_d = (bus.i_rden & empty) | (udf_q & ~bus.i_err_clr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.i_err_clr;
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench: depth-5 standard FIFO (d0) and depth-16 FWFT FIFO (d1) against a queue model.
module tb_sync_fifo_fwft;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       wren[2], rden[2], clr[2];
    logic [7:0] wd[2];
    int         afc[2], aec[2];
    int         dep[2];
    bit         fw[2];

    int nvec = 0;
    int nerr = 0;

    sync_fifo_fwft_if #(.P_DATA_WIDTH(8), .P_CNT_WIDTH(3)) f0 ();
    sync_fifo_fwft_if #(.P_DATA_WIDTH(8), .P_CNT_WIDTH(5)) f1 ();

    assign f0.i_wren = wren[0];  assign f0.i_wdata = wd[0];  assign f0.i_rden = rden[0];
    assign f0.i_err_clr = clr[0];
    assign f0.i_cfg_almost_full = 3'(afc[0]);  assign f0.i_cfg_almost_empty = 3'(aec[0]);
    assign f1.i_wren = wren[1];  assign f1.i_wdata = wd[1];  assign f1.i_rden = rden[1];
    assign f1.i_err_clr = clr[1];
    assign f1.i_cfg_almost_full = 5'(afc[1]);  assign f1.i_cfg_almost_empty = 5'(aec[1]);

    sync_fifo_fwft #(.P_DATA_WIDTH(8), .P_FIFO_DEPTH(5), .P_FWFT(0)) u_std (
        .i_clk(clk), .i_rst_n(rst_n), .bus(f0.slave));
    sync_fifo_fwft #(.P_DATA_WIDTH(8), .P_FIFO_DEPTH(16), .P_FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .bus(f1.slave));

    // Model: contents as a queue, standard-mode output register, sticky flags.
    logic [7:0] mq[2][$];
    bit   [7:0] rdm[2];
    bit         vm[2], ovm[2], udm[2];

    initial forever begin
        bit fl, em, wa, ra;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                rdm[k] = 8'h00; vm[k] = 1'b0; ovm[k] = 1'b0; udm[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                fl = (mq[k].size() == dep[k]);
                em = (mq[k].size() == 0);
                wa = wren[k] && !fl;
                ra = rden[k] && !em;
                if (ERR) begin
                    if (wren[k] && fl) ovm[k] = 1'b1; else if (clr[k]) ovm[k] = 1'b0;
                    if (rden[k] && em) udm[k] = 1'b1; else if (clr[k]) udm[k] = 1'b0;
                end
                if (!fw[k]) begin
                    vm[k] = ra;
                    if (ra) rdm[k] = mq[k][0];
                end
                if (ra) void'(mq[k].pop_front());
                if (wa) mq[k].push_back(wd[k]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic [7:0] rd, input logic v, input logic fl,
                       input logic em, input logic af, input logic ae, input int lvl,
                       input logic ov, input logic ud);
        int n;
        logic [7:0] erd;
        logic ev;
        n   = mq[k].size();
        erd = fw[k] ? ((n != 0) ? mq[k][0] : 8'h00) : rdm[k];
        ev  = fw[k] ? (n != 0) : vm[k];
        chk($sformatf("d%0d.level", k), 32'(lvl), 32'(n));
        chk($sformatf("d%0d.full", k), 32'(fl), 32'(n == dep[k]));
        chk($sformatf("d%0d.empty", k), 32'(em), 32'(n == 0));
        chk($sformatf("d%0d.almost_full", k), 32'(af), 32'(n >= afc[k]));
        chk($sformatf("d%0d.almost_empty", k), 32'(ae), 32'(n <= aec[k]));
        chk($sformatf("d%0d.valid", k), 32'(v), 32'(ev));
        chk($sformatf("d%0d.rdata", k), 32'(rd), 32'(erd));
        chk($sformatf("d%0d.overflow", k), 32'(ov), 32'(ovm[k]));
        chk($sformatf("d%0d.underflow", k), 32'(ud), 32'(udm[k]));
    endtask

    initial forever begin
        @(negedge clk);
        cmp(0, f0.o_rdata, f0.o_rddata_valid, f0.o_fifo_full, f0.o_fifo_empty,
            f0.o_fifo_almost_full, f0.o_fifo_almost_empty, int'(f0.o_fifo_level),
            f0.o_overflow, f0.o_underflow);
        cmp(1, f1.o_rdata, f1.o_rddata_valid, f1.o_fifo_full, f1.o_fifo_empty,
            f1.o_fifo_almost_full, f1.o_fifo_almost_empty, int'(f1.o_fifo_level),
            f1.o_overflow, f1.o_underflow);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dep[0] = 5;  fw[0] = 1'b0;  afc[0] = 4;  aec[0] = 1;
        dep[1] = 16; fw[1] = 1'b1;  afc[1] = 14; aec[1] = 2;
        for (int k = 0; k < 2; k++) begin
            wren[k] = 1'b0; rden[k] = 1'b0; clr[k] = 1'b0; wd[k] = 8'h00;
        end
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst.empty", 32'(f0.o_fifo_empty), 32'd1);
        chk("rst.level", 32'(f1.o_fifo_level), 32'd0);
        chk("rst.valid", 32'(f0.o_rddata_valid), 32'd0);
        chk("rst.rdata", 32'(f0.o_rdata), 32'd0);
        chk("rst.ae", 32'(f1.o_fifo_almost_empty), 32'd1);
        chk("rst.af", 32'(f1.o_fifo_almost_full), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // d0: fill to full, overflow attempt, drain with one-cycle latency
        wren[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin wd[0] = 8'(8'h11 + i); tick(); end
        wd[0] = 8'hAA; tick();
        wren[0] = 1'b0;
        chk("fill.level", 32'(f0.o_fifo_level), 32'd5);
        chk("fill.full", 32'(f0.o_fifo_full), 32'd1);
        chk("fill.overflow", 32'(f0.o_overflow), 32'(ERR));
        chk("fill.model", 32'(mq[0].size()), 32'd5);
        rden[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain.rdata", 32'(f0.o_rdata), 32'(8'h11 + i));
            chk("drain.valid", 32'(f0.o_rddata_valid), 32'd1);
        end
        rden[0] = 1'b0;
        tick();
        chk("drain.valid_off", 32'(f0.o_rddata_valid), 32'd0);
        chk("drain.hold", 32'(f0.o_rdata), 32'h15);
        chk("drain.empty", 32'(f0.o_fifo_empty), 32'd1);

        // d0: 12 cycles of write+read, pointers wrap twice
        for (int i = 0; i < 12; i++) begin
            wren[0] = 1'b1; wd[0] = 8'(8'h20 + i); rden[0] = (i >= 1);
            tick();
            chk("wrap.level", 32'(f0.o_fifo_level), 32'd1);
            if (i >= 1) chk("wrap.rdata", 32'(f0.o_rdata), 32'(8'h20 + i - 1));
        end
        wren[0] = 1'b0; rden[0] = 1'b1;
        tick();
        chk("wrap.last", 32'(f0.o_rdata), 32'h2B);
        rden[0] = 1'b0;

        // d0: underflow, set-beats-clear, then clear
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("clr.overflow", 32'(f0.o_overflow), 32'd0);
        rden[0] = 1'b1; tick();
        chk("udf.valid", 32'(f0.o_rddata_valid), 32'd0);
        chk("udf.set", 32'(f0.o_underflow), 32'(ERR));
        clr[0] = 1'b1; tick();
        chk("udf.set_wins", 32'(f0.o_underflow), 32'(ERR));
        chk("udf.valid2", 32'(f0.o_rddata_valid), 32'd0);
        rden[0] = 1'b0; tick(); clr[0] = 1'b0;
        chk("udf.cleared", 32'(f0.o_underflow), 32'd0);

        // d1: FWFT fall-through and pop
        wren[1] = 1'b1; wd[1] = 8'h3C; tick(); wren[1] = 1'b0;
        chk("fwft.valid", 32'(f1.o_rddata_valid), 32'd1);
        chk("fwft.rdata", 32'(f1.o_rdata), 32'h3C);
        rden[1] = 1'b1; tick(); rden[1] = 1'b0;
        chk("fwft.pop_valid", 32'(f1.o_rddata_valid), 32'd0);
        chk("fwft.pop_rdata", 32'(f1.o_rdata), 32'h00);

        // d1: threshold walk to full, then rd+wr at full
        wren[1] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wd[1] = 8'(i); tick();
            chk("thr.ae", 32'(f1.o_fifo_almost_empty), 32'(i <= 2));
            chk("thr.af", 32'(f1.o_fifo_almost_full), 32'(i >= 14));
        end
        rden[1] = 1'b1; wd[1] = 8'hEE; tick();
        wren[1] = 1'b0; rden[1] = 1'b0;
        chk("full_rw.level", 32'(f1.o_fifo_level), 32'd15);
        chk("full_rw.overflow", 32'(f1.o_overflow), 32'(ERR));
        chk("full_rw.head", 32'(f1.o_rdata), 32'd2);

        // d1: drain to 7, then async reset mid-transfer
        rden[1] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst.level", 32'(f1.o_fifo_level), 32'd7);
        chk("pre_rst.head", 32'(f1.o_rdata), 32'd10);
        wren[1] = 1'b1; wd[1] = 8'h77;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst.empty", 32'(f1.o_fifo_empty), 32'd1);
        chk("arst.level", 32'(f1.o_fifo_level), 32'd0);
        chk("arst.valid", 32'(f1.o_rddata_valid), 32'd0);
        chk("arst.overflow", 32'(f1.o_overflow), 32'd0);
        chk("arst.underflow", 32'(f0.o_underflow), 32'd0);
        wren[1] = 1'b0; rden[1] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through (FWFT) read mode, overflow/underflow protection with an exact fill-level output, and optional sticky error flags. Sits between any producer and consumer in the same clock domain. All flags are derived from a registered level counter, with no look-ahead terms.

## Interface
Parameters:
- P_DATA_WIDTH, 8, data word width.
- P_FIFO_DEPTH, 16, number of storage words; any value ≥ 2.
- P_FWFT, 0, read mode: 0 = standard, 1 = FWFT.
- P_CNT_WIDTH, $clog2(P_FIFO_DEPTH+1), width of level and threshold buses.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wren  in  1  write request.
- i_wdata  in  P_DATA_WIDTH  write data.
- i_rden  in  1  read request; in FWFT mode this is a pop/acknowledge.
- o_rdata  out  P_DATA_WIDTH  read data.
- o_rddata_valid  out  1  o_rdata is valid.
- o_fifo_full  out  1  level == P_FIFO_DEPTH.
- o_fifo_empty  out  1  level == 0.
- i_cfg_almost_full  in  P_CNT_WIDTH  almost-full threshold.
- i_cfg_almost_empty  in  P_CNT_WIDTH  almost-empty threshold.
- o_fifo_almost_full  out  1  level ≥ i_cfg_almost_full.
- o_fifo_almost_empty  out  1  level ≤ i_cfg_almost_empty.
- o_fifo_level  out  P_CNT_WIDTH  number of stored words.
- i_err_clr  in  1  clears the sticky error flags.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Write accepted: wr_acc = i_wren & ~o_fifo_full. Read accepted: rd_acc = i_rden & ~o_fifo_empty.
- Full and empty are the registered state of the current cycle. A same-cycle opposite operation does not unblock a request:
  - At full, a simultaneous read and write gives: read accepted, write dropped, overflow event.
  - At empty, a simultaneous read and write gives: write accepted, read dropped, underflow event.
- Pointers are binary, 0..P_FIFO_DEPTH-1. Each increments on its accept and wraps from P_FIFO_DEPTH-1 to 0. There is no power-of-two requirement.
- Level update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Storage array is not reset. Contents are only observable after being written.
- Standard mode (P_FWFT=0):
  - On rd_acc, o_rdata <= mem[rd_ptr] and o_rddata_valid <= 1.
  - Otherwise o_rddata_valid <= 0 and o_rdata holds its value.
- FWFT mode (P_FWFT=1):
  - o_rddata_valid = ~o_fifo_empty.
  - o_rdata = mem[rd_ptr] when valid, else all zeros.
  - i_rden with valid=1 pops the head word.
- Almost flags are combinational compares of the registered level against the live threshold inputs. Compares are unsigned at P_CNT_WIDTH bits.

## Timing
- Reset values: o_fifo_empty=1, o_fifo_full=0, o_fifo_level=0, o_rdata=0, o_rddata_valid=0, o_overflow=0, o_underflow=0. Pointers are 0.
- Almost flags after reset follow their compare rules against level 0.
- Write latency: a word written at edge N is counted in level and flags after edge N.
- Standard-mode read latency: 1 cycle. rd_acc at edge N gives o_rdata/o_rddata_valid after edge N.
- FWFT read latency:
  - A write into an empty FIFO at edge N gives valid=1 with that word after edge N.
  - After a pop, the next word is presented combinationally after the same edge.
- Reset asserted mid-operation returns to the reset state immediately (asynchronous). Stored data is then logically discarded.
- Sustained simultaneous read and write at any level between 1 and P_FIFO_DEPTH−1 gives full throughput with the level constant.

## Configuration
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - o_overflow sets on i_wren & o_fifo_full.
  - o_underflow sets on i_rden & o_fifo_empty.
  - Both hold until a cycle with i_err_clr=1 and no new set event; a set event wins over a clear in the same cycle.
- Not defined: o_overflow and o_underflow are constant 0 and i_err_clr is ignored. Data-path protection (dropping rejected requests) is unchanged either way.

## Test plan
- Depth 5, standard mode: write 5 words 0x11..0x15 → level 5, full=1. Write 0xAA → dropped, overflow=1. Read 5 → data 0x11..0x15, each 1 cycle after its rden.
- Depth 5: 12 cycles of interleaved write/read with continuous wrap → data order preserved, level never exceeds 5, pointers wrap 4→0.
- Empty FIFO: rden alone → valid stays 0, underflow=1. Then i_err_clr pulse → underflow=0. With macro undefined → underflow stays 0 throughout.
- FWFT, depth 16: write 0x3C to empty → next cycle valid=1, o_rdata=0x3C. Pop with rden → valid=0, o_rdata=0.
- Thresholds af=14, ae=2, depth 16: fill one word at a time → almost_empty=1 for levels 0–2, almost_full=1 from level 14. At full, simultaneous rd+wr → level 15, overflow=1.
- Assert i_rst_n low with level 7 mid-transfer → immediately empty=1, level=0, valid=0, error flags=0.
